nibble_product_accumulator: RTL and testbench
=============================================

# nibble_product_accumulator

Receive-side sequencer for the 8x8 sequential multiplier. It drives the nibble-select lines that steer operand nibbles into the 4x4 multiplier. It then takes the four 8-bit partial products that come back, shifts each by 0, 4 or 8 bits, and accumulates them into the 16-bit product. A start/done handshake connects it to the surrounding datapath.

## Interface
- `PP_W`, default 8: partial-product width.
- `PROD_W`, default 16: accumulated product width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new multiply. Sampled only in IDLE or DONE.
- `pp_in` in `PP_W`: partial product from the 4x4 multiplier for the current step.
- `pp_valid` in 1: `pp_in` is valid this cycle.
- `sel_a` out 1: operand-A nibble select, 0 = low nibble, 1 = high nibble.
- `sel_b` out 1: operand-B nibble select, same encoding as `sel_a`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when `product` becomes final.
- `product` out `PROD_W`: accumulated result. Holds its value until the next accepted `start`.

## Operation
States and transitions:
- IDLE -> RUN on `start`.
- RUN -> DONE after the 4th accepted partial product.
- DONE -> IDLE unconditionally, or DONE -> RUN if `start` is high in DONE.

Step counter `cnt[1:0]`:
- Cleared when `start` is accepted.
- Increments on each RUN cycle with `pp_valid`=1.
- `sel_a` = `cnt[0]`, `sel_b` = `cnt[1]`, both combinational from `cnt`.
- Outside RUN, `sel_a`/`sel_b` = 0.

Shift per step:

| `cnt` | Operand nibbles | Shift |
|---|---|---|
| 0 | A_lo·B_lo | 0 |
| 1 | A_hi·B_lo | 4 |
| 2 | A_lo·B_hi | 4 |
| 3 | A_hi·B_hi | 8 |

Accumulation:
- Each accepted step does `product <= product + ({8'b0, pp_in} << shift)`, with the result truncated to `PROD_W`.
- No overflow is possible, since the maximum product is 0xFE01.
- The accepting `start` cycle clears `product` to 0.

Handshake and boundary rules:
- `pp_valid`=0 in RUN: a stall. `cnt`, `product` and the selects hold.
- `pp_valid` outside RUN is ignored.
- `start` while in RUN is ignored, and the multiply in progress continues.
- `start` in DONE is accepted: `product` clears and `cnt`=0 on the next edge.
- `reset` at any time, including mid-RUN: the next state is IDLE with `cnt`=0, `product`=0, `done`=0, `busy`=0, `sel_a`=`sel_b`=0.

## Timing
- Reset values: `product`=0x0000, `done`=0, `busy`=0, `sel_a`=0, `sel_b`=0, state IDLE.
- `start` sampled at edge k: `busy` is high from cycle k+1.
- The selects for step n are valid in the same cycle as `pp_in` for step n. The upstream 4x4 multiplier is combinational, so `pp_in` returns within the same cycle.
- With `pp_valid` held high, steps are accepted at edges k+1 through k+4.
- DONE follows the last acceptance:
  - State is DONE with `done`=1 in cycle k+5.
  - `busy`=0 in that cycle.
  - `product` is final in that same cycle.
- Minimum start-to-done latency is 5 cycles. Each stall cycle adds 1.
- Back-to-back operation: `start` held through DONE gives a new multiply every 5 cycles.

## Structure
- Shared package `seq_mult_pkg` contains:
  - State enum `acc_state_t`: IDLE, RUN, DONE.
  - Shift constants `SHIFT_LL`=0, `SHIFT_HL`=4, `SHIFT_LH`=4, `SHIFT_HH`=8.
  - Width constants `PP_W` and `PROD_W`.
- One sub-module, `shift_adder`: combinational zero-extend, shift by the 2-bit step code, and add to the accumulator.
- The FSM, counter and product register stay in the top module.

## Test plan
- Reset applied mid-RUN after 2 steps -> the next cycle shows IDLE, `product`=0, `busy`=0, `sel_a`=`sel_b`=0. A following `start` produces a correct full multiply.
- A=0xFF, B=0xFF; `pp_in`=0xE1 for all 4 steps, `pp_valid` high -> `sel` sequence (a,b) = (0,0), (1,0), (0,1), (1,1). `done` pulses at k+5 with `product`=0xFE01.
- A=0x12, B=0x34; `pp_in` = 0x08, 0x04, 0x06, 0x03 -> `product`=0x03A8, which is 936.
- Same as the A=0x12 case, with `pp_valid` low for 2 cycles between steps 1 and 2 -> `sel` holds (1,0) during the stall. `done` is at k+7 with `product`=0x03A8.
- `start` pulsed during RUN, and `pp_valid` pulsed in IDLE -> both are ignored and the result is unchanged. `start` in the DONE cycle -> `busy` at the next cycle, `product` cleared to 0, a second result follows correctly.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier receive side.
package seq_mult_pkg;

  localparam int unsigned PP_W    = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam logic [SHIFT_W-1:0] SHIFT_LL = 4'd0;
  localparam logic [SHIFT_W-1:0] SHIFT_HL = 4'd4;
  localparam logic [SHIFT_W-1:0] SHIFT_LH = 4'd4;
  localparam logic [SHIFT_W-1:0] SHIFT_HH = 4'd8;

  // Bit shift applied to the partial product of a given step.
  function automatic logic [SHIFT_W-1:0] step_shift(input logic [CNT_W-1:0] step);
    logic [SHIFT_W-1:0] sh;
    case (step)
      2'd0:    sh = SHIFT_LL;
      2'd1:    sh = SHIFT_HL;
      2'd2:    sh = SHIFT_LH;
      default: sh = SHIFT_HH;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/nibble_product_accumulator_shift_adder.sv
// Zero-extends a partial product, shifts it by its step weight and adds it to the accumulator.
module shift_adder
  import seq_mult_pkg::*;
#(
  parameter int unsigned PP_W   = seq_mult_pkg::PP_W,
  parameter int unsigned PROD_W = seq_mult_pkg::PROD_W
) (
  input  logic [PROD_W-1:0] i_acc,
  input  logic [PP_W-1:0]   i_pp,
  input  logic [CNT_W-1:0]  i_step,
  output logic [PROD_W-1:0] o_sum_c
);

  logic [PROD_W-1:0] w_ext;
  logic [PROD_W-1:0] w_shifted;

  // Sum wraps at PROD_W; the largest 8x8 product cannot overflow 16 bits.
  always_comb begin
    w_ext     = PROD_W'(i_pp);
    w_shifted = w_ext << step_shift(i_step);
    o_sum_c   = i_acc + w_shifted;
  end

endmodule

// File: rtl/nibble_product_accumulator.sv
// Sequences the four nibble products of an 8x8 multiply and accumulates the 16-bit result.
module nibble_product_accumulator
  import seq_mult_pkg::*;
#(
  parameter int unsigned PP_W   = seq_mult_pkg::PP_W,
  parameter int unsigned PROD_W = seq_mult_pkg::PROD_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [PP_W-1:0]   i_pp_in,
  input  logic              i_pp_valid,
  output logic              o_sel_a,
  output logic              o_sel_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [PROD_W-1:0] o_product
);

  localparam logic [CNT_W-1:0] LAST_STEP = 2'd3;

  acc_state_t        r_state;
  acc_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PROD_W-1:0] r_product;
  logic [PROD_W-1:0] w_product_nxt;
  logic [PROD_W-1:0] w_sum;
  logic              r_sel_a;
  logic              r_sel_b;
  logic              r_busy;
  logic              r_done;

  shift_adder #(
    .PP_W   (PP_W),
    .PROD_W (PROD_W)
  ) u_shift_adder (
    .i_acc   (r_product),
    .i_pp    (i_pp_in),
    .i_step  (r_cnt),
    .o_sum_c (w_sum)
  );

  // State, step counter, accumulator and registered status/select outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_product <= '0;
      r_sel_a   <= 1'b0;
      r_sel_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_sel_a   <= (w_state_nxt == RUN) & w_cnt_nxt[0];
      r_sel_b   <= (w_state_nxt == RUN) & w_cnt_nxt[1];
      r_busy    <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  // Next-state, counter and accumulator update; stalls simply hold everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = '0;
          w_product_nxt = '0;
        end
      end
      RUN: begin
        if (i_pp_valid) begin
          w_product_nxt = w_sum;
          w_cnt_nxt     = r_cnt + 2'd1;
          if (r_cnt == LAST_STEP) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (i_start) begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = '0;
          w_product_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_product_nxt = '0;
      end
    endcase
  end

  assign o_sel_a   = r_sel_a;
  assign o_sel_b   = r_sel_b;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_nibble_product_accumulator.sv
// Self-checking bench: the bench plays the combinational 4x4 multiplier and tracks the
// expected behaviour with a step-count/weighted-sum model.
module tb_nibble_product_accumulator;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_pp_in;
  logic        i_pp_valid;
  logic        o_sel_a;
  logic        o_sel_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_product;

  int n_tests = 0;
  int n_fail  = 0;

  int m_phase;
  int m_steps;
  int m_acc;

  always #5 clk = ~clk;

  nibble_product_accumulator dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_pp_in    (i_pp_in),
    .i_pp_valid (i_pp_valid),
    .o_sel_a    (o_sel_a),
    .o_sel_b    (o_sel_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_product  (o_product)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Weight of a step: 16^(number of high nibbles involved).
  function automatic int weight(input int s);
    return 1 << (4 * ((s % 2) + (s / 2)));
  endfunction

  function automatic int nib(input int v, input logic hi);
    return (hi === 1'b1) ? ((v >> 4) & 15) : (v & 15);
  endfunction

  // Compare every output against the model in the middle of the cycle.
  task automatic check(output bit dn);
    bit run;
    @(negedge clk);
    run = (m_phase == PH_RUN);
    cmp("busy",    int'(o_busy),    int'(run));
    cmp("done",    int'(o_done),    int'(m_phase == PH_DONE));
    cmp("sel_a",   int'(o_sel_a),   run ? (m_steps % 2) : 0);
    cmp("sel_b",   int'(o_sel_b),   run ? (m_steps / 2) : 0);
    cmp("product", int'(o_product), m_acc);
    dn = (o_done === 1'b1);
  endtask

  // Apply inputs for the coming edge and advance the model across it.
  task automatic drive(input bit st, input bit pv, input bit rst, input int a, input int b);
    int pp;
    pp = pv ? nib(a, o_sel_a) * nib(b, o_sel_b) : int'($urandom_range(0, 255));
    i_start    = st;
    i_pp_valid = pv;
    i_reset    = rst;
    i_pp_in    = 8'(pp);
    if (rst) begin
      m_phase = PH_IDLE; m_steps = 0; m_acc = 0;
    end else if (m_phase == PH_IDLE) begin
      if (st) begin m_phase = PH_RUN; m_steps = 0; m_acc = 0; end
    end else if (m_phase == PH_RUN) begin
      if (pv) begin
        m_acc = (m_acc + pp * weight(m_steps)) & 16'hFFFF;
        m_steps++;
        if (m_steps == 4) m_phase = PH_DONE;
      end
    end else begin
      if (st) begin m_phase = PH_RUN; m_steps = 0; m_acc = 0; end
      else m_phase = PH_IDLE;
    end
  endtask

  // One multiply: optional stall of stall_len cycles once stall_step steps are in.
  task automatic run_mult(input int a, input int b, input int stall_step, input int stall_len,
                          input bit poke_start, input bit restart, input bit skip_start,
                          output int prod, output int lat);
    bit dn;
    bit pv;
    int stalls;
    stalls = stall_len;
    prod   = -1;
    lat    = -1;
    if (!skip_start) begin
      check(dn);
      drive(1'b1, 1'b0, 1'b0, a, b);
    end
    for (int i = 1; i <= 40; i++) begin
      check(dn);
      if (skip_start && i == 1) begin
        cmp("restart_busy", int'(o_busy), 1);
        cmp("restart_clear", int'(o_product), 0);
      end
      if (dn) begin
        prod = int'(o_product);
        lat  = i;
        drive(restart, 1'($urandom_range(0, 1)), 1'b0, a, b);
        break;
      end
      pv = 1'b1;
      if (m_phase == PH_RUN && m_steps == stall_step && stalls > 0) begin
        pv = 1'b0;
        stalls--;
      end
      drive(poke_start && i == 2, pv, 1'b0, a, b);
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no done for a=0x%0h b=0x%0h", a, b);
    end
  endtask

  initial begin
    bit dn;
    int p;
    int l;
    int a;
    int b;
    int sl;
    bit rs;
    bit prev_rs;

    i_start = 1'b0; i_pp_valid = 1'b0; i_pp_in = 8'h00; i_reset = 1'b1;
    m_phase = PH_IDLE; m_steps = 0; m_acc = 0;

    // Reset values.
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    check(dn);
    cmp("rst_product", int'(o_product), 0);
    cmp("rst_busy", int'(o_busy), 0);
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    check(dn);
    drive(1'b0, 1'b0, 1'b0, 0, 0);

    // Reset in the middle of a run after two accepted steps.
    check(dn);
    drive(1'b1, 1'b0, 1'b0, 8'h12, 8'h34);
    check(dn);
    drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34);
    check(dn);
    drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34);
    check(dn);
    cmp("mid_sel_b", int'(o_sel_b), 1);
    cmp("mid_partial", int'(o_product), 16'h0048);
    drive(1'b0, 1'b1, 1'b1, 8'h12, 8'h34);
    check(dn);
    cmp("mid_rst_busy", int'(o_busy), 0);
    cmp("mid_rst_product", int'(o_product), 0);
    cmp("mid_rst_sel", int'({o_sel_a, o_sel_b}), 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);

    // Directed multiplies.
    run_mult(8'h12, 8'h34, -1, 0, 1'b0, 1'b0, 1'b0, p, l);
    cmp("after_rst_prod", p, 16'h03A8);
    cmp("after_rst_lat", l, 5);
    run_mult(8'hFF, 8'hFF, -1, 0, 1'b0, 1'b0, 1'b0, p, l);
    cmp("ff_prod", p, 16'hFE01);
    cmp("ff_lat", l, 5);
    run_mult(8'h12, 8'h34, 1, 2, 1'b0, 1'b0, 1'b0, p, l);
    cmp("stall_prod", p, 16'h03A8);
    cmp("stall_lat", l, 7);

    // pp_valid noise while idle, start poked mid-run, then restart from DONE.
    repeat (3) begin
      check(dn);
      drive(1'b0, 1'b1, 1'b0, 8'h77, 8'h99);
    end
    run_mult(8'h12, 8'h34, -1, 0, 1'b1, 1'b1, 1'b0, p, l);
    cmp("poke_prod", p, 16'h03A8);
    cmp("poke_lat", l, 5);
    run_mult(8'hA7, 8'h5C, -1, 0, 1'b0, 1'b0, 1'b1, p, l);
    cmp("b2b_prod", p, 16'h3C04);
    cmp("b2b_lat", l, 5);

    // Randomized multiplies with random stalls, gaps and back-to-back restarts.
    prev_rs = 1'b0;
    for (int t = 0; t < 25; t++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      sl = int'($urandom_range(0, 3));
      rs = (t != 24) && ($urandom_range(0, 2) == 0);
      if (!prev_rs) begin
        repeat (int'($urandom_range(0, 2))) begin
          check(dn);
          drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end
      end
      run_mult(a, b, int'($urandom_range(0, 3)), sl, 1'($urandom_range(0, 1)), rs, prev_rs, p, l);
      cmp("rand_prod", p, a * b);
      cmp("rand_lat", l, 5 + sl);
      prev_rs = rs;
    end

    check(dn);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    check(dn);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
